// File: rtl/gray_step_ctrl_if.sv
// Board-side signal bundle for the Gray step controller.
// The master drives switches and keys, and the controller (slave) drives the LEDs and status.
interface gray_step_ctrl_if;
    logic [3:0] sw;
    logic       key_step;
    logic       key_mode;
    logic       key_load;
    logic [7:0] led;
    logic [1:0] mode;
    logic       wrap;

    modport master (
        output sw, key_step, key_mode, key_load,
        input  led, mode, wrap
    );

    modport slave (
        input  sw, key_step, key_mode, key_load,
        output led, mode, wrap
    );
endinterface

// File: rtl/gray_step_ctrl.sv
// Sequencer for the 4-bit binary/Gray LED datapath.
// It combines key synchronisers, debouncers, an auto-run prescaler and the mode FSM.
module gray_step_ctrl #(
    parameter int DIV_CNT = 12_000_000,
    parameter int DEB_CNT = 240_000
) (
    input  logic            clk,
    input  logic            rst_n,
    gray_step_ctrl_if.slave bus
);

    localparam int DEB_W = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
    localparam int DIV_W = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CNT - 1);

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_RUN_UP   = 2'b01;
    localparam logic [1:0] ST_RUN_DOWN = 2'b10;

    // Key index map: 0 = step, 1 = mode, 2 = load.
    logic [2:0]       key_raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       key_level;
    logic [2:0]       press;
    logic [DEB_W-1:0] deb_cnt [3];

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [3:0]       count;
    logic [3:0]       count_next;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] presc_next;
    logic             wrap_q;
    logic             wrap_next;
    logic             running;
    logic             tick;
    logic             step_press;
    logic             mode_press;
    logic             load_press;
    logic [3:0]       gray;

    assign key_raw = {bus.key_load, bus.key_mode, bus.key_step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DEB_CNT straight cycles of disagreement.
    // Only a falling acceptance emits a press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level <= 3'b111;
            press     <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != key_level[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        key_level[i] <= sync2[i];
                        deb_cnt[i]   <= '0;
                        press[i]     <= ~sync2[i];
                    end else begin
                        deb_cnt[i]   <= deb_cnt[i] + DEB_W'(1);
                        press[i]     <= 1'b0;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                    press[i]   <= 1'b0;
                end
            end
        end
    end

    assign step_press = press[0];
    assign mode_press = press[1];
    assign load_press = press[2];

    assign running = (state == ST_RUN_UP) || (state == ST_RUN_DOWN);
    assign tick    = running && (presc == DIV_LAST);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (mode_press) state_next = ST_RUN_UP;
            ST_RUN_UP:   if (mode_press) state_next = ST_RUN_DOWN;
            ST_RUN_DOWN: if (mode_press) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_next = presc + DIV_W'(1);
        if (mode_press || !running || (presc == DIV_LAST)) begin
            presc_next = '0;
        end
    end

    // A mode press wins over everything, including a tick in the same cycle.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (!mode_press) begin
            if (state == ST_IDLE) begin
                if (load_press) begin
                    count_next = bus.sw;
                end else if (step_press) begin
                    count_next = count + 4'd1;
                    wrap_next  = (count == 4'd15);
                end
            end else if (tick && (state == ST_RUN_UP)) begin
                count_next = count + 4'd1;
                wrap_next  = (count == 4'd15);
            end else if (tick && (state == ST_RUN_DOWN)) begin
                count_next = count - 4'd1;
                wrap_next  = (count == 4'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= 4'd0;
            presc  <= '0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            presc  <= presc_next;
            wrap_q <= wrap_next;
        end
    end

    assign gray     = {count[3], count[3] ^ count[2], count[2] ^ count[1], count[1] ^ count[0]};
    assign bus.led  = ~{count, gray};
    assign bus.mode = state;
    assign bus.wrap = wrap_q;

endmodule

// File: doc/gray_step_ctrl.md
Name: gray_step_ctrl

Overview:
- Sequencer for the 4-bit binary/Gray datapath on the board.
- Owns a 4-bit binary count register and steps it in one of four ways: single-step by push-button, free-run up, free-run down, or load from the DIP switches.
- Drives the 8 active-low LEDs with the binary count and its Gray encoding.
- Contains button synchronisers, debouncers, a run-rate prescaler and the mode FSM.

Parameters:
- DIV_CNT, 12_000_000, clk cycles per auto-run step (1 Hz at 12 MHz); minimum 2.
- DEB_CNT, 240_000, clk cycles a key level must stay stable before it is accepted (20 ms at 12 MHz); minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous active-low
- sw  input  4  binary value used by load
- key_step  input  1  push-button, active-low, asynchronous to clk; single-step
- key_mode  input  1  push-button, active-low, asynchronous; cycles the mode
- key_load  input  1  push-button, active-low, asynchronous; loads sw
- led  output  8  active-low LEDs; [7:4] = ~binary count, [3:0] = ~Gray(count)
- mode  output  2  current FSM state encoding
- wrap  output  1  one-clk pulse when count wraps

Behaviour:
- Reset, async on rst_n low:
  - count = 0, FSM = IDLE, prescaler = 0, debouncers hold released level (1).
  - led = 8'hFF, mode = 2'b00, wrap = 0.
  - Reset asserted mid-run aborts immediately; no step completes after deassertion until a new tick or press.
- Key path, per key:
  - 2-flop synchroniser, then a stability counter.
  - Accepted level changes only after the synchronised input has differed from the accepted level for DEB_CNT consecutive cycles; any bounce restarts the count.
  - Accepted 1->0 transition produces exactly one 1-cycle press pulse. Release produces nothing.
- FSM states (mode encoding):
  - IDLE = 00, RUN_UP = 01, RUN_DOWN = 10. Encoding 11 is unused and recovers to IDLE next cycle.
  - mode press advances IDLE -> RUN_UP -> RUN_DOWN -> IDLE.
  - Every mode transition clears the prescaler.
- IDLE:
  - step press: count <= count + 1 (mod 16).
  - load press: count <= sw, taken from the sw value sampled on that clk, no sync required (static switches).
  - Prescaler held at 0.
- RUN_UP / RUN_DOWN:
  - Prescaler counts 0..DIV_CNT-1. At DIV_CNT-1 it issues a tick and returns to 0.
  - Tick: count +1 or -1 (mod 16).
  - step and load presses are ignored.
- Priority in the same cycle: mode press > load press > step press. Lower-priority pulses are dropped, not queued.
- A mode press coinciding with a tick: the FSM changes and the tick's count update is suppressed.
- Latency: press pulse or tick in cycle N -> count updated at edge ending cycle N. led and mode are combinational from registers and valid in cycle N+1.
- Gray encoding: g[3] = b[3]; g[i] = b[i+1] ^ b[i] for i = 2..0.
- wrap:
  - Registered 1-cycle pulse when count moves 15->0 on increment or 0->15 on decrement.
  - Not asserted by load, even if the loaded value is 0 or 15.
- Consecutive stepped codes differ in exactly one Gray bit, including across wrap.

Test Plan:
All tests use DIV_CNT=4, DEB_CNT=3.
- Reset: rst_n low mid-run with count=9 -> led=8'hFF, mode=00, wrap=0 asynchronously. After release, count stays 0 with no keys pressed.
- Debounce: key_step low for 2 cycles then high -> no step. Low held 5 cycles -> count 0->1 exactly once, led=8'hEE (~0001, ~0001). Bounce of 1-0-1-0 -> single step only.
- Load: sw=4'b1011, key_load press in IDLE -> count=11, Gray=1110, led=8'h41, wrap=0. Load with sw=0 from count 15 -> wrap stays 0.
- Auto-up with wrap: load 14, mode press -> RUN_UP. Ticks every 4 cycles give 14 -> 15 -> 0 -> 1. wrap pulses 1 cycle on 15->0. Each Gray transition changes exactly 1 bit.
- Auto-down: mode press twice from IDLE -> RUN_DOWN. From count 1: 1 -> 0 -> 15 -> 14, wrap pulse on 0->15. A third mode press returns to IDLE, and count holds indefinitely.
- Priority: in IDLE, step + load pulses in the same cycle -> count = sw, no increment. In RUN_UP, mode press aligned with a tick -> mode = 10, count unchanged that cycle. step press in RUN_UP -> ignored.
